// File: rtl/wait_port_arbiter.sv
// Two-source wait-state arbiter: glueclock and COM-port cycles are captured,
// served one at a time through the SPI slave, and completed by wait_end or timeout.
module wait_port_arbiter #(
    parameter int unsigned         TO_W   = 16,
    parameter logic [TO_W-1:0]     TO_MAX = 16'hFFFF
) (
    input  logic       fclk,
    input  logic       rst_n,
    input  logic       glu_req,
    input  logic       com_req,
    input  logic [7:0] glu_addr,
    input  logic [7:0] com_addr,
    input  logic [7:0] glu_wdata,
    input  logic [7:0] com_wdata,
    input  logic       glu_rnw,
    input  logic       com_rnw,
    output logic       glu_wait,
    output logic       com_wait,
    output logic       glu_done,
    output logic       com_done,
    output logic [7:0] rdata,
    output logic       timeout,
    output logic [1:0] status,
    output logic       status_wrn,
    output logic [7:0] wait_addr,
    output logic [7:0] wait_write,
    input  logic [7:0] wait_read,
    input  logic       wait_end
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SERVE = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic            glu_pend_q, glu_pend_d;
    logic            com_pend_q, com_pend_d;
    logic [7:0]      glu_addr_q, glu_addr_d;
    logic [7:0]      com_addr_q, com_addr_d;
    logic [7:0]      glu_wdata_q, glu_wdata_d;
    logic [7:0]      com_wdata_q, com_wdata_d;
    logic            glu_rnw_q, glu_rnw_d;
    logic            com_rnw_q, com_rnw_d;
    logic            grant_com_q, grant_com_d;
    logic            last_com_q, last_com_d;
    logic [TO_W-1:0] timer_q, timer_d;
    logic [1:0]      status_q, status_d;
    logic            status_wrn_q, status_wrn_d;
    logic [7:0]      wait_addr_q, wait_addr_d;
    logic [7:0]      wait_write_q, wait_write_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            glu_wait_q, glu_wait_d;
    logic            com_wait_q, com_wait_d;
    logic            glu_done_q, glu_done_d;
    logic            com_done_q, com_done_d;
    logic            timeout_q, timeout_d;
    logic            pick_com_s;
    logic [TO_W-1:0] timer_inc_s;

    assign timer_inc_s = timer_q + {{(TO_W-1){1'b0}}, 1'b1};
    // COM wins only when glueclock is idle or glueclock was granted last.
    assign pick_com_s  = com_pend_q & (~glu_pend_q | ~last_com_q);

    // Request capture, arbitration and the IDLE/SERVE/DONE sequencer.
    always_comb begin
        state_d      = state_q;
        glu_pend_d   = glu_pend_q;
        com_pend_d   = com_pend_q;
        glu_addr_d   = glu_addr_q;
        com_addr_d   = com_addr_q;
        glu_wdata_d  = glu_wdata_q;
        com_wdata_d  = com_wdata_q;
        glu_rnw_d    = glu_rnw_q;
        com_rnw_d    = com_rnw_q;
        grant_com_d  = grant_com_q;
        last_com_d   = last_com_q;
        timer_d      = timer_q;
        status_d     = status_q;
        status_wrn_d = status_wrn_q;
        wait_addr_d  = wait_addr_q;
        wait_write_d = wait_write_q;
        rdata_d      = rdata_q;
        glu_done_d   = 1'b0;
        com_done_d   = 1'b0;
        timeout_d    = 1'b0;

        if (glu_req && !glu_pend_q) begin
            glu_pend_d  = 1'b1;
            glu_addr_d  = glu_addr;
            glu_wdata_d = glu_wdata;
            glu_rnw_d   = glu_rnw;
        end else begin
            glu_pend_d  = glu_pend_d;
        end

        if (com_req && !com_pend_q) begin
            com_pend_d  = 1'b1;
            com_addr_d  = com_addr;
            com_wdata_d = com_wdata;
            com_rnw_d   = com_rnw;
        end else begin
            com_pend_d  = com_pend_d;
        end

        case (state_q)
            IDLE: begin
                if (glu_pend_q || com_pend_q) begin
                    grant_com_d = pick_com_s;
                    last_com_d  = pick_com_s;
                    timer_d     = {TO_W{1'b0}};
                    state_d     = SERVE;
                    if (pick_com_s) begin
                        com_pend_d   = 1'b0;
                        wait_addr_d  = com_addr_q;
                        wait_write_d = com_wdata_q;
                        status_wrn_d = com_rnw_q;
                        status_d     = 2'b10;
                    end else begin
                        glu_pend_d   = 1'b0;
                        wait_addr_d  = glu_addr_q;
                        wait_write_d = glu_wdata_q;
                        status_wrn_d = glu_rnw_q;
                        status_d     = 2'b01;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SERVE: begin
                timer_d = timer_inc_s;
                // wait_end is checked first so it wins over a coincident expiry.
                if (wait_end || (timer_inc_s == TO_MAX)) begin
                    state_d    = DONE;
                    status_d   = 2'b00;
                    glu_done_d = ~grant_com_q;
                    com_done_d = grant_com_q;
                    if (wait_end) begin
                        rdata_d = status_wrn_q ? wait_read : rdata_q;
                    end else begin
                        rdata_d   = status_wrn_q ? 8'hFF : rdata_q;
                        timeout_d = 1'b1;
                    end
                end else begin
                    state_d = SERVE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                status_d = 2'b00;
            end
        endcase

        glu_wait_d = glu_pend_d | ((state_d == SERVE) & ~grant_com_d);
        com_wait_d = com_pend_d | ((state_d == SERVE) &  grant_com_d);
    end

    // State and output registers; reset drops any transaction in flight.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            glu_pend_q   <= 1'b0;
            com_pend_q   <= 1'b0;
            glu_addr_q   <= 8'h00;
            com_addr_q   <= 8'h00;
            glu_wdata_q  <= 8'h00;
            com_wdata_q  <= 8'h00;
            glu_rnw_q    <= 1'b0;
            com_rnw_q    <= 1'b0;
            grant_com_q  <= 1'b0;
            last_com_q   <= 1'b1;
            timer_q      <= {TO_W{1'b0}};
            status_q     <= 2'b00;
            status_wrn_q <= 1'b0;
            wait_addr_q  <= 8'h00;
            wait_write_q <= 8'h00;
            rdata_q      <= 8'hFF;
            glu_wait_q   <= 1'b0;
            com_wait_q   <= 1'b0;
            glu_done_q   <= 1'b0;
            com_done_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            glu_pend_q   <= glu_pend_d;
            com_pend_q   <= com_pend_d;
            glu_addr_q   <= glu_addr_d;
            com_addr_q   <= com_addr_d;
            glu_wdata_q  <= glu_wdata_d;
            com_wdata_q  <= com_wdata_d;
            glu_rnw_q    <= glu_rnw_d;
            com_rnw_q    <= com_rnw_d;
            grant_com_q  <= grant_com_d;
            last_com_q   <= last_com_d;
            timer_q      <= timer_d;
            status_q     <= status_d;
            status_wrn_q <= status_wrn_d;
            wait_addr_q  <= wait_addr_d;
            wait_write_q <= wait_write_d;
            rdata_q      <= rdata_d;
            glu_wait_q   <= glu_wait_d;
            com_wait_q   <= com_wait_d;
            glu_done_q   <= glu_done_d;
            com_done_q   <= com_done_d;
            timeout_q    <= timeout_d;
        end
    end

    assign glu_wait   = glu_wait_q;
    assign com_wait   = com_wait_q;
    assign glu_done   = glu_done_q;
    assign com_done   = com_done_q;
    assign rdata      = rdata_q;
    assign timeout    = timeout_q;
    assign status     = status_q;
    assign status_wrn = status_wrn_q;
    assign wait_addr  = wait_addr_q;
    assign wait_write = wait_write_q;

endmodule

// File: tb/tb_wait_port_arbiter.sv
// Directed bench for wait_port_arbiter: a transaction table plus hand-written
// sequences for arbitration, retrigger and reset-in-service.
module tb_wait_port_arbiter;

    logic       fclk = 1'b0;
    logic       rst_n;
    logic       glu_req, com_req;
    logic [7:0] glu_addr, com_addr, glu_wdata, com_wdata;
    logic       glu_rnw, com_rnw;
    logic       glu_wait, com_wait, glu_done, com_done;
    logic [7:0] rdata;
    logic       timeout;
    logic [1:0] status;
    logic       status_wrn;
    logic [7:0] wait_addr, wait_write, wait_read;
    logic       wait_end;

    int n_cmp = 0;
    int n_err = 0;
    int glu_done_cnt = 0;
    int com_done_cnt = 0;

    wait_port_arbiter #(.TO_W(16), .TO_MAX(16'd20)) dut (
        .fclk(fclk), .rst_n(rst_n),
        .glu_req(glu_req), .com_req(com_req),
        .glu_addr(glu_addr), .com_addr(com_addr),
        .glu_wdata(glu_wdata), .com_wdata(com_wdata),
        .glu_rnw(glu_rnw), .com_rnw(com_rnw),
        .glu_wait(glu_wait), .com_wait(com_wait),
        .glu_done(glu_done), .com_done(com_done),
        .rdata(rdata), .timeout(timeout), .status(status),
        .status_wrn(status_wrn), .wait_addr(wait_addr), .wait_write(wait_write),
        .wait_read(wait_read), .wait_end(wait_end)
    );

    always #5 fclk = ~fclk;

    always @(posedge fclk) begin
        if (glu_done) glu_done_cnt <= glu_done_cnt + 1;
        if (com_done) com_done_cnt <= com_done_cnt + 1;
    end

    typedef struct {
        logic       com;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       rnw;
        int         delay;
        logic       use_end;
        logic [7:0] rd;
        logic [7:0] exp_rdata;
        logic       exp_to;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [1:0] code;
        logic       early;
        code = v.com ? 2'b10 : 2'b01;
        early = 1'b0;
        if (v.com) begin
            com_req = 1'b1; com_addr = v.addr; com_wdata = v.wdata; com_rnw = v.rnw;
        end else begin
            glu_req = 1'b1; glu_addr = v.addr; glu_wdata = v.wdata; glu_rnw = v.rnw;
        end
        tick();
        glu_req = 1'b0; com_req = 1'b0;
        chk($sformatf("v%0d wait_on_req", idx), v.com ? com_wait : glu_wait, 16'd1);
        chk($sformatf("v%0d status_pending", idx), status, 16'd0);
        tick();
        chk($sformatf("v%0d status_grant", idx), status, code);
        chk($sformatf("v%0d wait_addr", idx), wait_addr, v.addr);
        chk($sformatf("v%0d wait_write", idx), wait_write, v.wdata);
        chk($sformatf("v%0d status_wrn", idx), status_wrn, v.rnw);
        for (int c = 1; c <= v.delay; c++) begin
            if (c == v.delay && v.use_end) begin
                wait_end = 1'b1; wait_read = v.rd;
            end
            tick();
            wait_end = 1'b0;
            if (c < v.delay && (glu_done || com_done || status != code)) early = 1'b1;
        end
        chk($sformatf("v%0d early_done", idx), early, 16'd0);
        chk($sformatf("v%0d done", idx), v.com ? com_done : glu_done, 16'd1);
        chk($sformatf("v%0d other_done", idx), v.com ? glu_done : com_done, 16'd0);
        chk($sformatf("v%0d wait_fall", idx), v.com ? com_wait : glu_wait, 16'd0);
        chk($sformatf("v%0d timeout", idx), timeout, v.exp_to);
        chk($sformatf("v%0d status_done", idx), status, 16'd0);
        chk($sformatf("v%0d rdata", idx), rdata, v.exp_rdata);
        tick();
        chk($sformatf("v%0d done_one_cycle", idx), v.com ? com_done : glu_done, 16'd0);
    endtask

    // Wait (bounded) for the next grant, check it, then complete it with wait_end.
    task automatic finish_cur(input string name, input logic [1:0] code, input logic [7:0] addr);
        int n;
        n = 0;
        while (status == 2'b00 && n < 10) begin
            tick();
            n++;
        end
        chk({name, " grant_code"}, status, code);
        chk({name, " grant_addr"}, wait_addr, addr);
        wait_end = 1'b1; wait_read = 8'h3E;
        tick();
        wait_end = 1'b0;
        chk({name, " done"}, (code == 2'b10) ? com_done : glu_done, 16'd1);
        tick();
    endtask

    initial begin
        int g0, c0;
        vecs[0] = '{1'b0, 8'hF3, 8'h00, 1'b1, 10, 1'b1, 8'h5A, 8'h5A, 1'b0};
        vecs[1] = '{1'b1, 8'hC4, 8'h77, 1'b0,  5, 1'b1, 8'h99, 8'h5A, 1'b0};
        vecs[2] = '{1'b1, 8'h12, 8'h00, 1'b1,  1, 1'b1, 8'hA5, 8'hA5, 1'b0};
        vecs[3] = '{1'b0, 8'h40, 8'h3C, 1'b0,  3, 1'b1, 8'h11, 8'hA5, 1'b0};
        vecs[4] = '{1'b0, 8'h81, 8'h00, 1'b1, 20, 1'b0, 8'h00, 8'hFF, 1'b1};
        vecs[5] = '{1'b0, 8'h82, 8'h00, 1'b1, 20, 1'b1, 8'h6B, 8'h6B, 1'b0};
        vecs[6] = '{1'b1, 8'h55, 8'hE1, 1'b0, 20, 1'b0, 8'h00, 8'h6B, 1'b1};

        rst_n = 1'b0;
        glu_req = 1'b0; com_req = 1'b0;
        glu_addr = 8'h00; com_addr = 8'h00; glu_wdata = 8'h00; com_wdata = 8'h00;
        glu_rnw = 1'b0; com_rnw = 1'b0; wait_read = 8'h00; wait_end = 1'b0;
        #12;
        chk("rst status", status, 16'd0);
        chk("rst rdata", rdata, 16'h00FF);
        chk("rst waits", {glu_wait, com_wait}, 16'd0);
        chk("rst dones_to", {glu_done, com_done, timeout}, 16'd0);
        chk("rst wait_addr_write", {wait_addr, wait_write}, 16'd0);
        chk("rst status_wrn", status_wrn, 16'd0);
        tick();
        rst_n = 1'b1;
        tick();
        wait_end = 1'b1;
        tick();
        wait_end = 1'b0;
        tick();
        chk("idle wait_end ignored", glu_done_cnt + com_done_cnt, 16'd0);
        chk("idle status", status, 16'd0);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Simultaneous requests after a COM grant: glueclock first, then COM.
        glu_req = 1'b1; glu_addr = 8'hA1; glu_rnw = 1'b1;
        com_req = 1'b1; com_addr = 8'hB1; com_rnw = 1'b1;
        tick();
        glu_req = 1'b0; com_req = 1'b0;
        tick();
        chk("sim1 com_wait_while_glu", com_wait, 16'd1);
        finish_cur("sim1 first", 2'b01, 8'hA1);
        finish_cur("sim1 second", 2'b10, 8'hB1);

        // After a lone glueclock grant, a simultaneous pair goes to COM first.
        glu_req = 1'b1; glu_addr = 8'hA2;
        tick();
        glu_req = 1'b0;
        finish_cur("solo glu", 2'b01, 8'hA2);
        glu_req = 1'b1; glu_addr = 8'hA3;
        com_req = 1'b1; com_addr = 8'hB3;
        tick();
        glu_req = 1'b0; com_req = 1'b0;
        finish_cur("sim2 first", 2'b10, 8'hB3);
        finish_cur("sim2 second", 2'b01, 8'hA3);
        tick();

        // Same-source retrigger with a duplicate request while pending.
        g0 = glu_done_cnt;
        glu_req = 1'b1; glu_addr = 8'h31;
        tick();
        glu_req = 1'b0;
        tick();
        chk("retrig grant1 addr", wait_addr, 16'h0031);
        tick();
        glu_req = 1'b1; glu_addr = 8'h32;
        tick();
        glu_req = 1'b0;
        tick();
        glu_req = 1'b1; glu_addr = 8'h33;
        tick();
        glu_req = 1'b0;
        chk("retrig addr held", wait_addr, 16'h0031);
        wait_end = 1'b1;
        tick();
        wait_end = 1'b0;
        chk("retrig done1", glu_done, 16'd1);
        chk("retrig wait through done", glu_wait, 16'd1);
        tick();
        finish_cur("retrig second", 2'b01, 8'h32);
        repeat (4) tick();
        chk("retrig done count", glu_done_cnt - g0, 16'd2);
        chk("retrig wait idle", glu_wait, 16'd0);

        // Reset while in SERVE drops the transaction silently.
        g0 = glu_done_cnt; c0 = com_done_cnt;
        glu_req = 1'b1; glu_addr = 8'h77;
        tick();
        glu_req = 1'b0;
        tick();
        tick();
        chk("rsrv in service", status, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("rsrv status", status, 16'd0);
        chk("rsrv waits", {glu_wait, com_wait}, 16'd0);
        chk("rsrv rdata", rdata, 16'h00FF);
        glu_req = 1'b1;
        tick();
        glu_req = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_end = 1'b1;
        tick();
        wait_end = 1'b0;
        repeat (3) tick();
        chk("rsrv no done", (glu_done_cnt - g0) + (com_done_cnt - c0), 16'd0);
        chk("rsrv no request", {glu_wait, status}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
